// File: rtl/hpq_pkg.sv
// Shared definitions for the distance/dot-product datapath: accumulator state
// encoding, the FP32 zero constant and an elaboration-time log2 helper.
package hpq_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        RED   = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_dot_acc_if.sv
// Product stream in, vector sum out, between fpmul and the codebook/top-k stage.
// Both directions use valid/ready: a beat moves on a clock edge where vld&rdy are
// both high; the sender holds vld and data stable until that edge, and rdy may
// toggle freely without depending on vld.
interface fp_dot_acc_if #(
    parameter int DW = 32
);
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_dat;
    logic          in_last;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_dat;

    modport master (
        output in_vld, in_dat, in_last, out_rdy,
        input  in_rdy, out_vld, out_dat
    );

    modport slave (
        input  in_vld, in_dat, in_last, out_rdy,
        output in_rdy, out_vld, out_dat
    );
endinterface

// File: rtl/fp_dot_acc_fpadd.sv
// Pipelined FP32 adder (round-to-nearest-even), RI input + RP middle + RO output
// register stages; total latency RI+RP+RO cycles. RI and RO must be at least 1.
module fpadd #(
    parameter int RI = 1,
    parameter int RP = 2,
    parameter int RO = 1
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam int NO = RP + RO;

    function automatic logic [31:0] fp32_add(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] x, z, r;
        logic [7:0]  ex, ez;
        logic [26:0] mx, mz, mz_sh, m;
        logic [27:0] s28;
        logic [9:0]  e;
        logic [24:0] mr;
        logic        p_nan, q_nan, p_inf, q_inf, sticky, up;
        int          d, lz, sh;
        p_nan = (p[30:23] == 8'hff) && (p[22:0] != 23'd0);
        q_nan = (q[30:23] == 8'hff) && (q[22:0] != 23'd0);
        p_inf = (p[30:23] == 8'hff) && (p[22:0] == 23'd0);
        q_inf = (q[30:23] == 8'hff) && (q[22:0] == 23'd0);
        if (p_nan || q_nan || (p_inf && q_inf && (p[31] != q[31]))) begin
            r = 32'h7fc0_0000;
        end else if (p_inf) begin
            r = p;
        end else if (q_inf) begin
            r = q;
        end else begin
            // x carries the larger magnitude and therefore the result sign
            if (p[30:0] >= q[30:0]) begin
                x = p; z = q;
            end else begin
                x = q; z = p;
            end
            ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
            ez = (z[30:23] == 8'd0) ? 8'd1 : z[30:23];
            mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
            mz = {(z[30:23] != 8'd0), z[22:0], 3'b000};
            d  = int'(ex) - int'(ez);
            if (d >= 27) begin
                mz_sh  = 27'd0;
                sticky = |mz;
            end else begin
                mz_sh  = mz >> d;
                sticky = |(mz << (27 - d));
            end
            mz_sh[0] = mz_sh[0] | sticky;
            e = {2'b00, ex};
            if (x[31] == z[31]) begin
                s28 = {1'b0, mx} + {1'b0, mz_sh};
                if (s28[27]) begin
                    m    = s28[27:1];
                    m[0] = m[0] | s28[0];
                    e    = e + 10'd1;
                end else begin
                    m = s28[26:0];
                end
            end else begin
                m  = mx - mz_sh;
                lz = 27;
                for (int i = 0; i < 27; i++) begin
                    if (m[i]) lz = 26 - i;
                end
                // never normalise below the minimum exponent: leaves a denormal
                sh = lz;
                if (sh > int'(e) - 1) sh = int'(e) - 1;
                m = m << sh;
                e = e - 10'(sh);
            end
            up = m[2] & (m[1] | m[0] | m[3]);
            mr = {1'b0, m[26:3]} + {24'd0, up};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 10'd1;
            end
            if (m == 27'd0) begin
                r = {x[31] & z[31], 31'd0};
            end else if (int'(e) >= 255) begin
                r = {x[31], 8'hff, 23'd0};
            end else begin
                r = {x[31], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
            end
        end
        return r;
    endfunction

    logic [63:0] in_q  [RI];
    logic [31:0] out_q [NO];
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        in_q[0] <= {a, b};
        for (int i = 1; i < RI; i++) in_q[i] <= in_q[i-1];
        out_q[0] <= sum;
        for (int i = 1; i < NO; i++) out_q[i] <= out_q[i-1];
    end

    always_comb begin
        sum = fp32_add(in_q[RI-1][63:32], in_q[RI-1][31:0]);
    end

    assign y = out_q[NO-1];
endmodule

// File: rtl/fp_dot_acc.sv
// Streaming FP32 vector accumulator: LAT interleaved partial sums hide the adder
// latency, then a log2(LAT) tree reduces them onto one shared fpadd.
module fp_dot_acc
    import hpq_pkg::*;
#(
    parameter int DW  = 32,
    parameter int LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    fp_dot_acc_if.slave       bus,
    output state_t            dbg_state
);
    localparam int SW = clog2(LAT);
    localparam int CW = SW + 1;

    state_t          state, state_nx;
    logic            run;
    logic [SW-1:0]   ptr;
    logic [CW-1:0]   cnt, cnt_nx, red_n;
    logic [SW-1:0]   rnd, rnd_nx;
    logic [DW-1:0]   psum [LAT];
    logic [LAT-1:0]  tag_v;
    logic [SW-1:0]   tag_s [LAT];
    logic            wb_v;
    logic [SW-1:0]   wb_s;
    logic            issue, clr;
    logic [SW-1:0]   iss_s, i_lo, i_hi;
    logic [DW-1:0]   op_a, op_b, sum_y;

    fpadd #(
        .RI (1),
        .RP (LAT - 2),
        .RO (1)
    ) u_add (
        .clk (clk),
        .a   (op_a),
        .b   (op_b),
        .y   (sum_y)
    );

    assign wb_v      = tag_v[LAT-1];
    assign wb_s      = tag_s[LAT-1];
    assign bus.in_rdy  = run && (state == ACC);
    assign bus.out_vld = (state == OUT);
    assign bus.out_dat = (state == OUT) ? psum[0] : FP32_ZERO;
    assign dbg_state   = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rnd_nx   = rnd;
        issue    = 1'b0;
        clr      = 1'b0;
        iss_s    = ptr;
        op_a     = bus.in_dat;
        op_b     = psum[ptr];
        red_n    = CW'(LAT >> rnd);
        i_lo     = SW'({cnt, 1'b0});
        i_hi     = i_lo | SW'(1);
        case (state)
            ACC: begin
                if (run && bus.in_vld) begin
                    issue = 1'b1;
                    // the slot's previous result may be retiring this very cycle
                    if (wb_v && (wb_s == ptr)) op_b = sum_y;
                    if (bus.in_last) begin
                        state_nx = DRAIN;
                        cnt_nx   = '0;
                    end
                end
            end
            DRAIN: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(LAT - 1)) begin
                    state_nx = RED;
                    cnt_nx   = '0;
                    rnd_nx   = SW'(1);
                end
            end
            RED: begin
                // first red_n cycles issue pair sums, then LAT cycles let them retire
                if (cnt < red_n) begin
                    issue = 1'b1;
                    iss_s = cnt[SW-1:0];
                    op_a  = psum[i_lo];
                    op_b  = psum[i_hi];
                end
                cnt_nx = cnt + CW'(1);
                if (cnt == red_n + CW'(LAT) - CW'(1)) begin
                    cnt_nx = '0;
                    if (rnd == SW'(SW)) state_nx = OUT;
                    else                rnd_nx   = rnd + SW'(1);
                end
            end
            OUT: begin
                if (bus.out_rdy) begin
                    state_nx = ACC;
                    clr      = 1'b1;
                end
            end
            default: state_nx = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACC;
            run   <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            rnd   <= '0;
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                psum[i]  <= FP32_ZERO;
                tag_s[i] <= '0;
            end
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            cnt   <= cnt_nx;
            rnd   <= rnd_nx;
            if (run && (state == ACC)) ptr <= ptr + SW'(1);
            else if (clr)              ptr <= '0;
            tag_v    <= {tag_v[LAT-2:0], issue};
            tag_s[0] <= iss_s;
            for (int i = 1; i < LAT; i++) tag_s[i] <= tag_s[i-1];
            for (int i = 0; i < LAT; i++) begin
                if (clr)                             psum[i] <= FP32_ZERO;
                else if (wb_v && (wb_s == SW'(i)))   psum[i] <= sum_y;
            end
        end
    end
endmodule
